// File: rtl/xgmii_tx_framer.sv
// xgmii_tx_framer: wraps MAC frame words in XGMII start/preamble, CRC-32 FCS, terminate and inter-packet gap
module xgmii_tx_framer #(
  parameter int IPG_WORDS = 1
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [63:0] i_data,
  input  logic        i_last,
  input  logic [2:0]  i_last_bytes,
  output logic        o_ready,
  output logic [63:0] o_txd,
  output logic [7:0]  o_txc,
  output logic        o_frame_done,
  output logic        o_underrun
);
  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;
  typedef enum logic [1:0] {IDLE, DATA, TAIL, IPG} state_t;
  state_t state, state_d;
  logic [31:0] crc, crc_d, crc_upd, fcs, fcs_q;
  logic [3:0] n, n_q, cnt;
  logic [71:0] last_w, tail_w;
  logic [63:0] txd_d;
  logic [7:0] txc_d;
  logic done_d, und_d;
  function automatic logic [31:0] crc_bytes(input logic [31:0] c, input logic [63:0] d, input int nb);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++)
      if (k < nb) begin
        r = r ^ {24'h0, d[8*k+:8]};
        for (int b = 0; b < 8; b++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
      end
    return r;
  endfunction
  function automatic logic [71:0] build(input logic [63:0] d, input logic [31:0] f, input int nb, input int base);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      int v;
      v = k + base;
      if (v < nb) w[8*k+:8] = d[8*k+:8];
      else if (v < nb + 4) w[8*k+:8] = f[8*(v-nb)+:8];
      else begin
        w[64+k] = 1'b1;
        w[8*k+:8] = (v == nb + 4) ? 8'hFD : 8'h07;
      end
    end
    return w;
  endfunction
  assign n = (!i_last || i_last_bytes == 3'd0) ? 4'd8 : {1'b0, i_last_bytes};
  assign crc_upd = crc_bytes(crc, i_data, int'(n));
  assign fcs = ~crc_upd;
  assign last_w = build(i_data, fcs, int'(n), 0);
  assign tail_w = build(64'h0, fcs_q, int'(n_q), 8);
  assign o_ready = state == DATA;
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      crc <= '1;
      cnt <= '0;
      fcs_q <= '0;
      n_q <= '0;
      o_txd <= IDLE_W;
      o_txc <= '1;
      o_frame_done <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      state <= state_d;
      crc <= crc_d;
      cnt <= (state_d == IPG && state != IPG) ? 4'(IPG_WORDS - 1) : (state == IPG ? cnt - 4'd1 : cnt);
      if (state == DATA && i_valid && i_last) begin
        fcs_q <= fcs;
        n_q <= n;
      end
      o_txd <= txd_d;
      o_txc <= txc_d;
      o_frame_done <= done_d;
      o_underrun <= und_d;
    end
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = i_valid ? DATA : IDLE;
      DATA: state_d = !i_valid ? IPG : !i_last ? DATA : (n < 4'd4) ? IPG : TAIL;
      TAIL: state_d = IPG;
      IPG:  state_d = (cnt == 4'd0) ? IDLE : IPG;
    endcase
  end
  always_comb begin
    txd_d = IDLE_W;
    txc_d = 8'hFF;
    done_d = 1'b0;
    und_d = 1'b0;
    crc_d = crc;
    case (state)
      IDLE: if (i_valid) begin
        txd_d = START_W;
        txc_d = 8'h01;
      end
      DATA: if (!i_valid) begin
        txd_d = ERR_W;
        und_d = 1'b1;
        crc_d = '1;
      end else if (!i_last) begin
        txd_d = i_data;
        txc_d = 8'h00;
        crc_d = crc_upd;
      end else begin
        {txc_d, txd_d} = last_w;
        done_d = n < 4'd4;
        crc_d = '1;
      end
      TAIL: begin
        {txc_d, txd_d} = tail_w;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_xgmii_tx_framer.sv
// tb_xgmii_tx_framer: randomized frames scored against a byte-stream reference of the XGMII framing rules
module tb_xgmii_tx_framer;
  localparam int IPG = 3;
  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;
  typedef struct packed {logic [63:0] d; logic [7:0] c; logic done; logic und;} word_t;
  logic clk = 0, rst_n = 0, valid = 0, last = 0;
  logic [63:0] data = '0;
  logic [2:0] last_bytes = '0;
  logic ready, done, und;
  logic [63:0] txd;
  logic [7:0] txc;
  word_t exp_q[$];
  logic [7:0] fb[$];
  int tests = 0, fails = 0, idle_cnt = 0;
  bit have_end = 0, rdy_bad = 0, exact = 0;
  always #5 clk = ~clk;
  xgmii_tx_framer #(.IPG_WORDS(IPG)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .i_last(last),
    .i_last_bytes(last_bytes), .o_ready(ready), .o_txd(txd), .o_txc(txc),
    .o_frame_done(done), .o_underrun(und)
  );
  function automatic logic [31:0] ref_fcs();
    logic [31:0] c = '1;
    foreach (fb[i]) begin
      c ^= {24'h0, fb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction
  task automatic push_word(input logic [63:0] d, input logic [7:0] c, input logic dn, input logic u);
    word_t e;
    e.d = d; e.c = c; e.done = dn; e.und = u;
    exp_q.push_back(e);
  endtask
  task automatic push_model(input int drop_after);
    logic [7:0] ld[$];
    bit lc[$];
    logic [31:0] f;
    push_word(START_W, 8'h01, 0, 0);
    if (drop_after >= 0) begin
      for (int i = 0; i < 8 * (drop_after + 1); i++) begin ld.push_back(fb[i]); lc.push_back(0); end
    end else begin
      f = ref_fcs();
      foreach (fb[i]) begin ld.push_back(fb[i]); lc.push_back(0); end
      for (int j = 0; j < 4; j++) begin ld.push_back(f[8*j+:8]); lc.push_back(0); end
      ld.push_back(8'hFD); lc.push_back(1);
      while (ld.size() % 8 != 0) begin ld.push_back(8'h07); lc.push_back(1); end
    end
    for (int w = 0; w < ld.size() / 8; w++) begin
      word_t e;
      for (int k = 0; k < 8; k++) begin e.d[8*k+:8] = ld[8*w+k]; e.c[k] = lc[8*w+k]; end
      e.done = drop_after < 0 && w == ld.size() / 8 - 1;
      e.und = 0;
      exp_q.push_back(e);
    end
    if (drop_after >= 0) push_word(ERR_W, 8'hFF, 0, 1);
  endtask
  task automatic wait_accept(output bit ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        return;
      end
    end
    ok = 0;
    tests++; fails++;
    $display("FAIL accept_timeout: ready not seen within 100 cycles, required 1");
  endtask
  task automatic check_idle_out(input string name);
    tests++;
    if ({txd, txc, ready, done, und} !== {IDLE_W, 8'hFF, 3'b000}) begin
      fails++;
      $display("FAIL %s: got %h/%h rdy%0b d%0b u%0b, want %h/ff rdy0 d0 u0", name, txd, txc, ready, done, und, IDLE_W);
    end
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1 check_idle_out("async_reset");
    exp_q.delete();
    have_end = 0;
    valid = 0;
    repeat (2) @(posedge clk);
    #1 check_idle_out("reset_hold");
    rst_n = 1;
  endtask
  task automatic send_frame(input int drop_after, input int rst_after, input bit keep, input bit push);
    int len = fb.size();
    int nb = (len + 7) / 8;
    bit ok;
    if (push) push_model(drop_after);
    for (int b = 0; b < nb; b++) begin
      valid = 1;
      last = b == nb - 1;
      last_bytes = last ? 3'(len - 8 * b) : 3'($urandom);
      for (int k = 0; k < 8; k++) data[8*k+:8] = (8 * b + k < len) ? fb[8*b+k] : 8'($urandom);
      wait_accept(ok);
      if (!ok) begin valid = 0; return; end
      if (b == rst_after) begin do_reset(); return; end
      if (b == drop_after) begin valid = 0; return; end
    end
    if (!keep) valid = 0;
  endtask
  task automatic rand_bytes(input int len);
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
  endtask
  task automatic check_bytes(input int lo, input int len);
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'(lo + i));
  endtask
  always @(negedge clk) begin
    word_t e;
    if (rst_n) begin
      if (txd === IDLE_W && txc === 8'hFF) begin
        tests++;
        if (done !== 1'b0 || und !== 1'b0) begin
          fails++;
          $display("FAIL idle_pulse: got done %0b underrun %0b on idle word, want 0 0", done, und);
        end
        if (have_end) begin idle_cnt++; if (ready) rdy_bad = 1; end
      end else if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_word: got %h/%h with nothing pending, want idle", txd, txc);
      end else begin
        e = exp_q.pop_front();
        tests++;
        if ({txd, txc, done, und} !== e) begin
          fails++;
          $display("FAIL word: got %h/%h d%0b u%0b, want %h/%h d%0b u%0b", txd, txc, done, und, e.d, e.c, e.done, e.und);
        end
        if (e.c == 8'h01 && e.d == START_W && have_end) begin
          tests += 2;
          if (exact ? idle_cnt != IPG : idle_cnt < IPG) begin
            fails++;
            $display("FAIL ipg_gap: got %0d idle words, want %s%0d", idle_cnt, exact ? "" : ">=", IPG);
          end
          if (rdy_bad) begin
            fails++;
            $display("FAIL ipg_ready: got ready 1 during gap, want 0");
          end
          have_end = 0;
        end
        if (e.done || e.und) begin have_end = 1; idle_cnt = 0; rdy_bad = 0; end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 check_idle_out("reset_state");
    rst_n = 1;
    repeat (5) begin @(negedge clk); check_idle_out("idle_after_reset"); end
    check_bytes(8'h31, 9);
    push_word(START_W, 8'h01, 0, 0);
    push_word(64'h3837363534333231, 8'h00, 0, 0);
    push_word(64'h0707FDCBF4392639, 8'hE0, 1, 0);
    send_frame(-1, -1, 0, 0);
    repeat (10) @(posedge clk);
    check_bytes(0, 8);
    send_frame(-1, -1, 0, 1);
    repeat (10) @(posedge clk);
    rand_bytes(16);
    send_frame(0, -1, 0, 1);
    repeat (10) @(posedge clk);
    rand_bytes(32);
    send_frame(-1, 1, 0, 1);
    check_bytes(8'h31, 9);
    push_word(START_W, 8'h01, 0, 0);
    push_word(64'h3837363534333231, 8'h00, 0, 0);
    push_word(64'h0707FDCBF4392639, 8'hE0, 1, 0);
    send_frame(-1, -1, 0, 0);
    repeat (10) @(posedge clk);
    rand_bytes(12);
    send_frame(-1, -1, 1, 1);
    exact = 1;
    rand_bytes(7);
    send_frame(-1, -1, 1, 1);
    rand_bytes(16);
    send_frame(-1, -1, 1, 1);
    rand_bytes(3);
    send_frame(-1, -1, 0, 1);
    exact = 0;
    repeat (10) @(posedge clk);
    for (int it = 0; it < 40; it++) begin
      int len = $urandom_range(1, 40);
      int drop = (len > 8 && $urandom_range(0, 5) == 0) ? $urandom_range(0, (len + 7) / 8 - 2) : -1;
      rand_bytes(len);
      send_frame(drop, -1, 0, 1);
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    repeat (30) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d words still pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
